// File: rtl/lsu_pkg.sv
// lsu_pkg: definitions shared by the load/store path.
//   - load_select_e : load type encodings, also decoded by the load select unit
//   - lwf_state_e   : state encoding of the load_word_fetch FSM
// No ports; imported with `import lsu_pkg::*;`.
package lsu_pkg;

    typedef enum logic [2:0] {
        LS_BYTE               = 3'b000,
        LS_HALF_WORD          = 3'b001,
        LS_WORD               = 3'b010,
        LS_BYTE_UNSIGNED      = 3'b011,
        LS_HALF_WORD_UNSIGNED = 3'b100
    } load_select_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ0 = 3'd1,
        ST_RSP0 = 3'd2,
        ST_REQ1 = 3'd3,
        ST_RSP1 = 3'd4,
        ST_RESP = 3'd5
    } lwf_state_e;

endpackage

// File: rtl/load_split_detect.sv
// load_split_detect: decides whether an access of the given type at the
// given byte offset crosses a 32-bit word boundary.
// Ports:
//   load_select in  3 : access type (lsu_pkg::load_select_e encodings)
//   lb          in  2 : byte offset inside the word (addr[1:0])
//   split       out 1 : access touches the next word as well
// Purely combinational; shared with the store path.
module load_split_detect
    import lsu_pkg::*;
(
    input  logic [2:0] load_select,
    input  logic [1:0] lb,
    output logic       split
);

    always_comb begin
        split = 1'b0;
        case (load_select)
            LS_BYTE, LS_BYTE_UNSIGNED:         split = 1'b0;
            LS_HALF_WORD, LS_HALF_WORD_UNSIGNED: split = (lb == 2'b11);
            // WORD and any unknown encoding are handled as a full word.
            default:                           split = (lb != 2'b00);
        endcase
    end

endmodule

// File: rtl/load_word_fetch.sv
// load_word_fetch: sequential front end of the load path. Accepts one load
// request, fetches the aligned word (and the following word when the access
// straddles a word boundary) and hands the words, byte offset and load type
// to the load select unit. One request in flight at a time.
//
// Build option: LOAD_SPLIT_ACCESS_EN
//   defined   : straddling accesses are fetched as two reads; load_err = 0.
//   undefined : straddling accesses issue no read and complete at once with
//               load_err = 1 and zeroed data words.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   load_req/ready    : request handshake, accepted when both are high
//   load_addr/select  : byte address and load type, sampled on accept
//   load_valid        : one-cycle result pulse
//   load_err          : misaligned access trapped (qualified by load_valid)
//   out_data          : word at the aligned address
//   out_data_p1       : following word, 0 if not fetched
//   out_addr_lb       : byte offset of the accepted address
//   out_load_select   : load type of the accepted request
//   mem_req/addr/gnt  : word read request; request and address hold until gnt
//   mem_rvalid/rdata  : read response
//
// Handshake rules: load_req is taken on a clock edge where load_req and
// load_ready are both high. mem_req stays high with a constant mem_addr until
// the edge where mem_gnt is high; the data is then taken on the first edge
// with mem_rvalid high. mem_gnt and mem_rvalid are ignored in other states.
//
// Only DATA_WIDTH = 32 is meaningful: the byte-lane logic assumes 4 lanes.
module load_word_fetch
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [2:0]            load_select,
    output logic                  load_valid,
    output logic                  load_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] out_data_p1,
    output logic [1:0]            out_addr_lb,
    output logic [2:0]            out_load_select,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lwf_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;     // word-aligned base address
    logic                  split_now;

`ifdef LOAD_SPLIT_ACCESS_EN
    logic                  split_q;
`else
    logic                  err_q;
`endif

    load_split_detect u_split (
        .load_select (load_select),
        .lb          (load_addr[1:0]),
        .split       (split_now)
    );

    // Next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        load_valid = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_req) begin
`ifdef LOAD_SPLIT_ACCESS_EN
                    state_d = ST_REQ0;
`else
                    // A trapped straddling access skips memory entirely.
                    state_d = split_now ? ST_RESP : ST_REQ0;
`endif
                end
            end
            ST_REQ0: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_gnt) state_d = ST_RSP0;
            end
            ST_RSP0: begin
                if (mem_rvalid) begin
`ifdef LOAD_SPLIT_ACCESS_EN
                    state_d = split_q ? ST_REQ1 : ST_RESP;
`else
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef LOAD_SPLIT_ACCESS_EN
            ST_REQ1: begin
                mem_req  = 1'b1;
                // Wraps past the top of the address space by truncation.
                mem_addr = addr_q + ADDR_WIDTH'(4);
                if (mem_gnt) state_d = ST_RSP1;
            end
            ST_RSP1: begin
                if (mem_rvalid) state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                load_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LOAD_SPLIT_ACCESS_EN
    assign load_err = 1'b0;
`else
    assign load_err = (state_q == ST_RESP) && err_q;
`endif

    // State register and captured request/response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            out_data        <= '0;
            out_data_p1     <= '0;
            out_addr_lb     <= '0;
            out_load_select <= '0;
`ifdef LOAD_SPLIT_ACCESS_EN
            split_q         <= 1'b0;
`else
            err_q           <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (load_req) begin
                        addr_q          <= {load_addr[ADDR_WIDTH-1:2], 2'b00};
                        out_addr_lb     <= load_addr[1:0];
                        out_load_select <= load_select;
`ifdef LOAD_SPLIT_ACCESS_EN
                        split_q         <= split_now;
`else
                        err_q           <= split_now;
                        if (split_now) begin
                            out_data    <= '0;
                            out_data_p1 <= '0;
                        end
`endif
                    end
                end
                ST_RSP0: begin
                    if (mem_rvalid) begin
                        out_data <= mem_rdata;
`ifdef LOAD_SPLIT_ACCESS_EN
                        if (!split_q) out_data_p1 <= '0;
`else
                        out_data_p1 <= '0;
`endif
                    end
                end
`ifdef LOAD_SPLIT_ACCESS_EN
                ST_RSP1: begin
                    if (mem_rvalid) out_data_p1 <= mem_rdata;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
